// File: rtl/uart_tx_framed_if.sv
// Byte-source to UART transmitter handshake bundle (word, valid/ready, status).
// Latency: none, wires only.
// Backpressure: Tx_Ready low holds the source; Tx_DataValid is level-sensitive.
interface uart_tx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] Tx_Data;
  logic                 Tx_DataValid;
  logic                 Tx_Ready;
  logic                 Tx_Busy;
  logic                 TxDone;

  // Byte source side.
  modport master (
    output Tx_Data,
    output Tx_DataValid,
    input  Tx_Ready,
    input  Tx_Busy,
    input  TxDone
  );

  // Transmitter side.
  modport slave (
    input  Tx_Data,
    input  Tx_DataValid,
    output Tx_Ready,
    output Tx_Busy,
    output TxDone
  );
endinterface

// File: rtl/uart_tx_framed.sv
// Configurable UART transmitter: start, 5..9 data bits LSB first, optional parity, 1-2 stop bits.
// Latency: Tx falls on the accepting edge; TxDone pulses (1+DATA_BITS+P+STOP_BITS)*CLOCKS_PER_BIT cycles later.
// Backpressure: Tx_Ready is high only in IDLE; words are taken on Tx_DataValid & Tx_Ready, else held off.
module uart_tx_framed #(
  parameter int CLOCKS_PER_BIT = 10417,
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic            Clk,
  input  logic            Rst_n,
  uart_tx_framed_if.slave txIf,
  output logic            Tx
);

  // Counter widths are guarded so an illegal parameter still elaborates far enough to report.
  localparam int CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam bit HAS_PARITY = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam bit ODD_PARITY = (PARITY_MODE == 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadDataBits
    $error("uart_tx_framed: DATA_BITS=%0d outside 5..9", DATA_BITS);
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gBadStopBits
    $error("uart_tx_framed: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if (CLOCKS_PER_BIT < 2 || CLOCKS_PER_BIT > 65535) begin : gBadClocksPerBit
    $error("uart_tx_framed: CLOCKS_PER_BIT=%0d outside 2..65535", CLOCKS_PER_BIT);
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e               state,     stateNxt;
  logic [CNT_W-1:0]     bitCnt,    bitCntNxt;
  logic [IDX_W-1:0]     bitIdx,    bitIdxNxt;
  logic                 stopIdx,   stopIdxNxt;
  logic [DATA_BITS-1:0] shiftReg,  shiftNxt;
  logic                 parityBit, parityNxt;
  logic                 txReg,     txNxt;
  logic                 doneReg,   doneNxt;
  logic                 readyReg,  readyNxt;
  logic                 busyReg,   busyNxt;
  logic                 bitEnd;

  // Last cycle of the current bit period.
  assign bitEnd = (bitCnt == CNT_LAST);

  // Every output comes straight from a flop so nothing on the inputs reaches Tx combinationally.
  assign Tx            = txReg;
  assign txIf.TxDone   = doneReg;
  assign txIf.Tx_Ready = readyReg;
  assign txIf.Tx_Busy  = busyReg;

  // State and datapath registers; reset drives the line idle-high immediately.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      bitCnt    <= '0;
      bitIdx    <= '0;
      stopIdx   <= 1'b0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      txReg     <= 1'b1;
      doneReg   <= 1'b0;
      readyReg  <= 1'b0;
      busyReg   <= 1'b0;
    end else begin
      state     <= stateNxt;
      bitCnt    <= bitCntNxt;
      bitIdx    <= bitIdxNxt;
      stopIdx   <= stopIdxNxt;
      shiftReg  <= shiftNxt;
      parityBit <= parityNxt;
      txReg     <= txNxt;
      doneReg   <= doneNxt;
      readyReg  <= readyNxt;
      busyReg   <= busyNxt;
    end
  end

  // Frame sequencing: the next Tx level is decided one cycle ahead so it lands on the period boundary.
  always_comb begin
    stateNxt   = state;
    bitCntNxt  = bitCnt;
    bitIdxNxt  = bitIdx;
    stopIdxNxt = stopIdx;
    shiftNxt   = shiftReg;
    parityNxt  = parityBit;
    txNxt      = txReg;
    doneNxt    = 1'b0;
    readyNxt   = 1'b0;
    busyNxt    = 1'b0;

    if (state == IDLE) begin
      bitCntNxt = '0;
      txNxt     = 1'b1;
      // readyReg gates acceptance so the first edge after reset release only raises Tx_Ready.
      if (txIf.Tx_DataValid && readyReg) begin
        stateNxt  = START;
        shiftNxt  = txIf.Tx_Data;
        parityNxt = (^txIf.Tx_Data) ^ ODD_PARITY;
        txNxt     = 1'b0;
      end
    end else begin
      bitCntNxt = bitEnd ? '0 : bitCnt + CNT_W'(1);
      if (bitEnd) begin
        case (state)
          START: begin
            stateNxt  = DATA;
            bitIdxNxt = '0;
            txNxt     = shiftReg[0];
            shiftNxt  = shiftReg >> 1;
          end
          DATA: begin
            if (bitIdx == IDX_LAST) begin
              bitIdxNxt = '0;
              if (HAS_PARITY) begin
                stateNxt = PARITY;
                txNxt    = parityBit;
              end else begin
                stateNxt   = STOP;
                stopIdxNxt = 1'b0;
                txNxt      = 1'b1;
              end
            end else begin
              bitIdxNxt = bitIdx + IDX_W'(1);
              txNxt     = shiftReg[0];
              shiftNxt  = shiftReg >> 1;
            end
          end
          PARITY: begin
            stateNxt   = STOP;
            stopIdxNxt = 1'b0;
            txNxt      = 1'b1;
          end
          STOP: begin
            if (stopIdx == STOP_LAST) begin
              stateNxt   = IDLE;
              stopIdxNxt = 1'b0;
              doneNxt    = 1'b1;
              txNxt      = 1'b1;
            end else begin
              stopIdxNxt = 1'b1;
            end
          end
          default: begin
            stateNxt = IDLE;
            txNxt    = 1'b1;
          end
        endcase
      end
    end

    readyNxt = (stateNxt == IDLE);
    busyNxt  = (stateNxt != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: five instances covering 8N1, even/odd parity, 7-bit two-stop, and a fast 9-bit config.
// Expected line levels come from a frame-list model built from the word, not from the transmitter's internals.
// All sampling happens 1 time unit after the rising edge; inputs change at that same point.
module tb_uart_tx_framed;

  localparam int NDUT = 5;
  localparam int CPB_T [0:4] = '{16, 16, 16, 16, 3};
  localparam int DB_T  [0:4] = '{8, 8, 8, 7, 9};
  localparam int PM_T  [0:4] = '{0, 2, 1, 0, 1};
  localparam int SB_T  [0:4] = '{1, 1, 1, 2, 2};

  logic       Clk   = 1'b0;
  logic       Rst_n = 1'b1;
  logic [8:0] dat [0:4];
  logic [4:0] vld;
  wire  [4:0] txw, rdy, busy, done;

  int nVec  = 0;
  int nMiss = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    uart_tx_framed_if #(.DATA_BITS(DB_T[g])) bus ();
    assign bus.Tx_Data      = dat[g][DB_T[g]-1:0];
    assign bus.Tx_DataValid = vld[g];
    assign rdy[g]  = bus.Tx_Ready;
    assign busy[g] = bus.Tx_Busy;
    assign done[g] = bus.TxDone;
    uart_tx_framed #(
      .CLOCKS_PER_BIT(CPB_T[g]),
      .DATA_BITS     (DB_T[g]),
      .PARITY_MODE   (PM_T[g]),
      .STOP_BITS     (SB_T[g])
    ) dut (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .txIf (bus),
      .Tx   (txw[g])
    );
  end

  // Reference frame: list of line levels, one per bit period.
  logic expBits [0:15];
  int   expN;

  task automatic model_frame(input logic [8:0] word, input int d);
    int ones;
    ones = 0;
    expBits[0] = 1'b0;
    expN = 1;
    for (int i = 0; i < DB_T[d]; i++) begin
      expBits[expN] = word[i];
      ones += int'(word[i]);
      expN++;
    end
    if (PM_T[d] == 1 || PM_T[d] == 2) begin
      expBits[expN] = (PM_T[d] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      expN++;
    end
    for (int s = 0; s < SB_T[d]; s++) begin
      expBits[expN] = 1'b1;
      expN++;
    end
  endtask

  // Per-cycle capture of {Tx, Tx_Ready, Tx_Busy, TxDone}; k counts edges after the first one.
  logic [3:0] cap [0:1023];

  task automatic capture(input int d, input int n, input int dropAt, input int chgAt, input logic [8:0] chgVal);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk); #1;
      cap[k] = {txw[d], rdy[d], busy[d], done[d]};
      if (k == dropAt) vld[d] = 1'b0;
      if (k == chgAt)  dat[d] = chgVal;
    end
  endtask

  task automatic test_reset();
    vld = '0;
    for (int g = 0; g < NDUT; g++) dat[g] = '0;
    #2 Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      nVec++;
      if ({txw[g], rdy[g], busy[g], done[g]} !== 4'b1000) begin
        nMiss++;
        $display("FAIL reset_hold dut%0d: tx/rdy/busy/done=%b want 1000", g, {txw[g], rdy[g], busy[g], done[g]});
      end
    end
    Rst_n = 1'b1;
    nVec++;
    if (rdy !== 5'b00000) begin
      nMiss++;
      $display("FAIL reset_release_pre_edge: rdy=%b want 00000", rdy);
    end
    @(posedge Clk); #1;
    for (int g = 0; g < NDUT; g++) begin
      nVec++;
      if ({txw[g], rdy[g], busy[g], done[g]} !== 4'b1100) begin
        nMiss++;
        $display("FAIL reset_first_edge dut%0d: tx/rdy/busy/done=%b want 1100", g, {txw[g], rdy[g], busy[g], done[g]});
      end
    end
  endtask

  task automatic test_frame_formats();
    logic [8:0] words [0:3];
    int lenTbl [0:3];
    int parTbl [0:3];
    words  = '{9'h055, 9'h0A3, 9'h0A3, 9'h07F};
    lenTbl = '{160, 176, 176, 160};
    parTbl = '{0, 0, 1, 0};
    for (int d = 0; d < 4; d++) begin
      int L;
      int doneAt;
      int pIdx;
      model_frame(words[d], d);
      L = expN * CPB_T[d];
      nVec++;
      if (rdy[d] !== 1'b1) begin
        nMiss++;
        $display("FAIL fmt%0d_ready_before: rdy=%b want 1", d, rdy[d]);
      end
      dat[d] = words[d];
      vld[d] = 1'b1;
      capture(d, L + 3, 0, 3, ~words[d]);
      doneAt = -1;
      for (int k = 0; k < L + 3; k++)
        if (cap[k][0] === 1'b1 && doneAt < 0) doneAt = k;
      nVec++;
      if (doneAt != lenTbl[d]) begin
        nMiss++;
        $display("FAIL fmt%0d_done_cycle: TxDone at %0d want %0d", d, doneAt, lenTbl[d]);
      end
      for (int k = 0; k < L; k++) begin
        nVec++;
        if (cap[k] !== {expBits[k / CPB_T[d]], 3'b010}) begin
          nMiss++;
          $display("FAIL fmt%0d_cyc%0d: tx/rdy/busy/done=%b want %b", d, k, cap[k], {expBits[k / CPB_T[d]], 3'b010});
        end
      end
      nVec++;
      if (cap[L] !== 4'b1101) begin
        nMiss++;
        $display("FAIL fmt%0d_end: tx/rdy/busy/done=%b want 1101", d, cap[L]);
      end
      nVec++;
      if (cap[L+1] !== 4'b1100) begin
        nMiss++;
        $display("FAIL fmt%0d_after_end: tx/rdy/busy/done=%b want 1100", d, cap[L+1]);
      end
      if (PM_T[d] == 1 || PM_T[d] == 2) begin
        pIdx = (1 + DB_T[d]) * CPB_T[d] + CPB_T[d] / 2;
        nVec++;
        if (cap[pIdx][3] !== parTbl[d][0]) begin
          nMiss++;
          $display("FAIL fmt%0d_parity: tx=%b want %0d", d, cap[pIdx][3], parTbl[d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int L;
    nVec++;
    if (rdy[0] !== 1'b1) begin
      nMiss++;
      $display("FAIL b2b_ready_before: rdy=%b want 1", rdy[0]);
    end
    model_frame(9'h001, 0);
    L = expN * CPB_T[0];
    dat[0] = 9'h001;
    vld[0] = 1'b1;
    // Data switches to 0x02 mid-frame; valid stays high through the TxDone cycle.
    capture(0, 2 * L + 4, L + 1, 5, 9'h002);
    for (int k = 0; k < L; k++) begin
      nVec++;
      if (cap[k] !== {expBits[k / CPB_T[0]], 3'b010}) begin
        nMiss++;
        $display("FAIL b2b_f1_cyc%0d: tx/rdy/busy/done=%b want %b", k, cap[k], {expBits[k / CPB_T[0]], 3'b010});
      end
    end
    nVec++;
    if (cap[L] !== 4'b1101) begin
      nMiss++;
      $display("FAIL b2b_f1_done: tx/rdy/busy/done=%b want 1101", cap[L]);
    end
    model_frame(9'h002, 0);
    for (int j = 0; j < L; j++) begin
      nVec++;
      if (cap[L+1+j] !== {expBits[j / CPB_T[0]], 3'b010}) begin
        nMiss++;
        $display("FAIL b2b_f2_cyc%0d: tx/rdy/busy/done=%b want %b", j, cap[L+1+j], {expBits[j / CPB_T[0]], 3'b010});
      end
    end
    nVec++;
    if (cap[2*L+1] !== 4'b1101) begin
      nMiss++;
      $display("FAIL b2b_f2_done: tx/rdy/busy/done=%b want 1101", cap[2*L+1]);
    end
    nVec++;
    if (cap[2*L+2] !== 4'b1100) begin
      nMiss++;
      $display("FAIL b2b_idle_after: tx/rdy/busy/done=%b want 1100", cap[2*L+2]);
    end
  endtask

  task automatic test_reset_midframe();
    int L;
    int doneSeen;
    dat[0] = 9'h000;
    vld[0] = 1'b1;
    @(posedge Clk); #1;
    vld[0] = 1'b0;
    repeat (50) @(posedge Clk);
    #1;
    nVec++;
    if ({txw[0], busy[0]} !== 2'b01) begin
      nMiss++;
      $display("FAIL rstmid_in_frame: tx/busy=%b want 01", {txw[0], busy[0]});
    end
    #2 Rst_n = 1'b0;
    #1;
    nVec++;
    if ({txw[0], rdy[0], busy[0], done[0]} !== 4'b1000) begin
      nMiss++;
      $display("FAIL rstmid_async: tx/rdy/busy/done=%b want 1000", {txw[0], rdy[0], busy[0], done[0]});
    end
    doneSeen = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      doneSeen += int'(done[0]);
    end
    nVec++;
    if (doneSeen != 0 || txw[0] !== 1'b1) begin
      nMiss++;
      $display("FAIL rstmid_hold: done pulses=%0d tx=%b want 0 and 1", doneSeen, txw[0]);
    end
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    nVec++;
    if ({txw[0], rdy[0], busy[0], done[0]} !== 4'b1100) begin
      nMiss++;
      $display("FAIL rstmid_release: tx/rdy/busy/done=%b want 1100", {txw[0], rdy[0], busy[0], done[0]});
    end
    model_frame(9'h0C3, 0);
    L = expN * CPB_T[0];
    dat[0] = 9'h0C3;
    vld[0] = 1'b1;
    capture(0, L + 2, 0, 7, 9'h03C);
    for (int k = 0; k < L; k++) begin
      nVec++;
      if (cap[k] !== {expBits[k / CPB_T[0]], 3'b010}) begin
        nMiss++;
        $display("FAIL rstmid_c3_cyc%0d: tx/rdy/busy/done=%b want %b", k, cap[k], {expBits[k / CPB_T[0]], 3'b010});
      end
    end
    nVec++;
    if (cap[L] !== 4'b1101) begin
      nMiss++;
      $display("FAIL rstmid_c3_done: tx/rdy/busy/done=%b want 1101", cap[L]);
    end
  endtask

  task automatic test_random();
    int   fc;
    int   L;
    int   accepted;
    int   doneCnt;
    logic acc;
    logic mRdy;
    logic expTx;
    logic [3:0] expV;
    logic [3:0] gotV;
    fc = -1;
    accepted = 0;
    doneCnt = 0;
    model_frame(9'h000, 4);
    L = expN * CPB_T[4];
    for (int c = 0; c < 1600; c++) begin
      if (c < 1500) begin
        vld[4] = ($urandom_range(0, 7) != 0);
        dat[4] = 9'($urandom);
      end else begin
        vld[4] = 1'b0;
      end
      mRdy = (fc < 0) || (fc == L);
      acc  = mRdy && vld[4];
      if (acc) begin
        model_frame(dat[4], 4);
        accepted++;
      end
      @(posedge Clk); #1;
      if (acc) fc = 0;
      else if (fc >= 0 && fc < L) fc++;
      else fc = -1;
      expTx = (fc >= 0 && fc < L) ? expBits[fc / CPB_T[4]] : 1'b1;
      expV  = {expTx, (fc < 0 || fc == L), !(fc < 0 || fc == L), (fc == L)};
      gotV  = {txw[4], rdy[4], busy[4], done[4]};
      doneCnt += int'(done[4]);
      nVec++;
      if (gotV !== expV) begin
        nMiss++;
        $display("FAIL rnd_cyc%0d: tx/rdy/busy/done=%b want %b", c, gotV, expV);
      end
    end
    nVec++;
    if (doneCnt != accepted) begin
      nMiss++;
      $display("FAIL rnd_frame_count: TxDone pulses=%0d want %0d", doneCnt, accepted);
    end
  endtask

  initial begin
    test_reset();
    test_frame_formats();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors so far", nVec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_framed.md
Name: uart_tx_framed

Overview:
Parametrised UART transmitter. It is the next generation of the team's fixed 8N1 transmitter, adding configurable data width, parity and stop-bit count, a valid/ready input handshake and a byte latched at acceptance. It sits between a byte source (loopback logic, FIFO or register file) and the board TX pin. It is also the reference frame generator for the matching configurable receiver.

Parameters:
CLOCKS_PER_BIT, 10417, clock cycles per bit period (Clk frequency / baud rate); legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, parity setting: 0 = none, 1 = odd, 2 = even; value 3 is treated as none.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
Clk  input  1  system clock; all logic is on the rising edge.
Rst_n  input  1  asynchronous, active-low reset.
Tx_Data  input  DATA_BITS  frame payload; sampled only on acceptance.
Tx_DataValid  input  1  source has a word; level-sensitive.
Tx_Ready  output  1  block can accept a word this cycle.
Tx_Busy  output  1  a frame is in progress.
TxDone  output  1  one-cycle pulse when a frame completes.
Tx  output  1  serial line; idles high.

Behaviour:
- Reset: Clk and Rst_n are the only clock and reset. Rst_n is asynchronous and active-low.
- While Rst_n = 0: Tx = 1, Tx_Ready = 0, Tx_Busy = 0, TxDone = 0, state = IDLE, bit counter = 0, bit index = 0, shift register = 0.
- After reset release: Tx_Ready = 1 from the first Clk edge with Rst_n = 1.
- Handshake: a word is accepted on a rising edge where Tx_DataValid = 1 and Tx_Ready = 1.
  - Tx_Data is copied into an internal shift register at that edge.
  - Parity is computed from the accepted word at that same edge.
  - Tx_Data changes after acceptance have no effect on the current frame.
- Tx_Ready = 1 only in IDLE. Tx_Busy is the inverse of Tx_Ready, except during reset when both are 0.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: Tx = 1. On acceptance, go to START.
  - START: Tx = 0 for exactly CLOCKS_PER_BIT cycles. Tx goes low on the acceptance edge, so latency from acceptance to the start-bit edge is 0 cycles after the register.
  - DATA: DATA_BITS bit periods, LSB first. Each period is exactly CLOCKS_PER_BIT cycles. Bit index runs 0..DATA_BITS-1.
  - PARITY: present only when PARITY_MODE is 1 or 2; one bit period. Even mode sends the XOR of the data bits. Odd mode sends the inverted XOR.
  - STOP: Tx = 1 for STOP_BITS × CLOCKS_PER_BIT cycles.
- Frame completion: at the final edge of the last stop period, the state returns to IDLE, TxDone = 1 for exactly one cycle, and Tx_Ready returns to 1 in that same cycle.
- Back-to-back: with Tx_DataValid held high, the next word is accepted on the edge ending the TxDone cycle. The minimum gap between the end of one stop bit and the next start bit is therefore 1 Clk cycle.
- Bit timer:
  - Counter width is clog2(CLOCKS_PER_BIT).
  - It counts 0..CLOCKS_PER_BIT-1 and wraps to 0 on every bit boundary, never beyond.
  - It is held at 0 in IDLE.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × CLOCKS_PER_BIT cycles from acceptance edge to TxDone edge, where P = 1 if parity is enabled, else 0.
- Tx is driven from a flop; there is no combinational path from any input to Tx.
- Reset mid-frame: Tx returns to 1 immediately (asynchronously). The frame is abandoned, no TxDone is generated, and the block restarts in IDLE.
- Tx_DataValid dropping mid-frame is ignored.
- Tx_DataValid asserted during a frame is not accepted until IDLE.
- Illegal parameter values: out-of-range DATA_BITS or STOP_BITS must trigger a simulation-time $error.

Test Plan:
1. CLOCKS_PER_BIT = 16, DATA_BITS = 8, PARITY_MODE = 0, STOP_BITS = 1; send 0x55 -> Tx bit sequence 0,1,0,1,0,1,0,1,0,1; each level lasts 16 cycles; TxDone pulses 160 cycles after acceptance; Tx_Ready is low for exactly those 160 cycles.
2. PARITY_MODE = 2 (even), send 0xA3 -> parity bit = 0, frame is 176 cycles. Repeat with PARITY_MODE = 1 (odd) -> parity bit = 1.
3. DATA_BITS = 7, STOP_BITS = 2, PARITY_MODE = 0, send 0x7F -> Tx low for 16 cycles, high for 7 × 16 data cycles plus 32 stop cycles; TxDone at cycle 160.
4. Tx_DataValid held high with Tx_Data = 0x01 then 0x02 -> two frames, the second start bit begins exactly 1 cycle after the first TxDone cycle. Changing Tx_Data mid-frame does not alter the bits on Tx.
5. Assert Rst_n = 0 at cycle 50 of a frame -> Tx = 1 within the same cycle, no TxDone. After release, Tx_Ready = 1 and a new 0xC3 frame is transmitted correctly.
6. Randomised words at CLOCKS_PER_BIT = 3 (near the minimum), checked against a serial scoreboard -> every bit period is exactly 3 cycles and there are no dropped or duplicated frames.
